// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control FSM.
// State encoding, RV32I major opcodes, datapath mux encodings and the
// one-hot instruction class produced by mc_opcode_decode.
package mc_pkg;

  // Controller states. 6 and 7 are unused and recover to ST_TRAP.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM   = 2'b01;
  localparam logic [1:0] PC_SRC_ALU   = 2'b10;

  // Register-file write-back source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MDR = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // One-hot instruction class; exactly one bit is set for any opcode.
  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic nop;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: maps instr[6:0] to a one-hot class.
// FENCE and SYSTEM are executed as NOPs; anything unrecognised is illegal.
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  // Classify the major opcode; default to illegal
  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LOAD:                                    cls.load    = 1'b1;
      OPC_STORE:                                   cls.store   = 1'b1;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC:      cls.alu     = 1'b1;
      OPC_JAL:                                     cls.jal     = 1'b1;
      OPC_JALR:                                    cls.jalr    = 1'b1;
      OPC_BRANCH:                                  cls.branch  = 1'b1;
      OPC_FENCE, OPC_SYSTEM:                       cls.nop     = 1'b1;
      default:                                     cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle femtoRV32 core.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] over a
// single-ported memory and drives the datapath strobes and mux selects.
//
// Memory handshake: mem_req is held high with a stable address select and
// mem_we until a cycle in which mem_ready=1; that cycle completes the access.
// mem_ready is ignored whenever mem_req=0.
//
// Optional macro MC_PERF_CNT_EN adds cycle and retired-instruction counters
// (CNT_W bits, wrapping, frozen in TRAP); without it both outputs are 0.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             instret,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e    state_q;
  state_e    state_d;
  op_class_t cls;
  logic      illegal_q;

  // Un-gated strobes from the decode process
  logic       mem_req_c;
  logic       mem_addr_sel_c;
  logic       mem_we_c;
  logic       ir_we_c;
  logic       mdr_we_c;
  logic       pc_we_c;
  logic [1:0] pc_src_c;
  logic       reg_we_c;
  logic [1:0] wb_sel_c;
  logic       instret_c;

  mc_opcode_decode u_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore/qualified output decode
  always_comb begin
    state_d        = state_q;
    mem_req_c      = 1'b0;
    mem_addr_sel_c = 1'b0;
    mem_we_c       = 1'b0;
    ir_we_c        = 1'b0;
    mdr_we_c       = 1'b0;
    pc_we_c        = 1'b0;
    pc_src_c       = PC_SRC_PLUS4;
    reg_we_c       = 1'b0;
    wb_sel_c       = WB_SEL_ALU;
    instret_c      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = cls.illegal ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cls.branch) begin
          pc_we_c   = 1'b1;
          pc_src_c  = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
          instret_c = 1'b1;
          state_d   = ST_FETCH;
        end else if (cls.nop) begin
          pc_we_c   = 1'b1;
          instret_c = 1'b1;
          state_d   = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEMORY;
        end else if (cls.illegal) begin
          // IR cannot change after DECODE; kept only as a safe fallback
          state_d = ST_TRAP;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = cls.store;
        if (mem_ready) begin
          if (cls.load) begin
            mdr_we_c = 1'b1;
            state_d  = ST_WRITEBACK;
          end else begin
            pc_we_c   = 1'b1;
            instret_c = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        reg_we_c  = 1'b1;
        pc_we_c   = 1'b1;
        instret_c = 1'b1;
        state_d   = ST_FETCH;
        if (cls.load)                 wb_sel_c = WB_SEL_MDR;
        else if (cls.jal || cls.jalr) wb_sel_c = WB_SEL_PC4;
        if (cls.jal)       pc_src_c = PC_SRC_IMM;
        else if (cls.jalr) pc_src_c = PC_SRC_ALU;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Sticky illegal flag, set together with the entry into TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    illegal_q <= 1'b0;
    else if (state_d == ST_TRAP) illegal_q <= 1'b1;
  end

  // Strobes are forced low while reset is held so an aborted access never writes
  assign mem_req      = mem_req_c & ~rst;
  assign mem_addr_sel = mem_addr_sel_c & ~rst;
  assign mem_we       = mem_we_c & ~rst;
  assign ir_we        = ir_we_c & ~rst;
  assign mdr_we       = mdr_we_c & ~rst;
  assign pc_we        = pc_we_c & ~rst;
  assign pc_src       = rst ? PC_SRC_PLUS4 : pc_src_c;
  assign reg_we       = reg_we_c & ~rst;
  assign wb_sel       = rst ? WB_SEL_ALU : wb_sel_c;
  assign instret      = instret_c & ~rst;
  assign illegal      = illegal_q;
  assign state_o      = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instret_cnt_q;

  // Performance counters: free-running modulo 2^CNT_W, frozen in TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else if (state_q != ST_TRAP) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instret_c) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: randomized instruction stream with random
// memory wait states, checked at every retirement against a per-instruction
// reference model, plus directed reset, mid-access abort and trap scenarios.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 32;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_FENCE  = 7'b0001111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, pc_we;
  logic [1:0]       pc_src, wb_sel;
  logic             reg_we, instret, illegal;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc_tot  = 0;
  int ret_tot  = 0;

  logic [6:0] legal_ops [11] = '{T_LOAD, T_STORE, T_OP, T_OP_IMM, T_LUI, T_AUIPC,
                                 T_JAL, T_JALR, T_BRANCH, T_FENCE, T_SYSTEM};

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .instret      (instret),
    .illegal      (illegal),
    .state_o      (state_o),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [6:0] strobes();
    return {mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we, instret};
  endfunction

  // ---------------- reference model ----------------
  // Expected record for one instruction, given fetch wait f, memory wait m:
  // {pad3, pc_src@retire, wb_sel@retire, #reg_we, #pc_we, #mdr_we, #ir_we,
  //  #store cycles, #data-addr request cycles, #fetch request cycles, latency}
  function automatic logic [W-1:0] model(input logic [6:0] opc, input int f,
                                         input int m, input logic bt);
    int lat, reg_n, mdr_n, st_n, a1_n;
    logic [1:0] ps, ws;
    ps = 2'b00; ws = 2'b00; reg_n = 0; mdr_n = 0; st_n = 0; a1_n = 0;
    case (opc)
      T_BRANCH:         begin lat = f + 3; ps = bt ? 2'b01 : 2'b00; end
      T_FENCE, T_SYSTEM: lat = f + 3;
      T_LOAD:           begin lat = f + m + 5; ws = 2'b01; reg_n = 1; mdr_n = 1; a1_n = m + 1; end
      T_STORE:          begin lat = f + m + 4; st_n = m + 1; a1_n = m + 1; end
      T_JAL:            begin lat = f + 4; ps = 2'b01; ws = 2'b10; reg_n = 1; end
      T_JALR:           begin lat = f + 4; ps = 2'b10; ws = 2'b10; reg_n = 1; end
      default:          begin lat = f + 4; reg_n = 1; end
    endcase
    return {3'b000, ps, ws, 2'(reg_n), 2'd1, 2'(mdr_n), 2'd1,
            4'(st_n), 4'(a1_n), 4'(f + 1), 5'(lat)};
  endfunction

  // Expected phase (0 fetch,1 decode,2 execute,3 memory,4 writeback) at cycle k
  function automatic int exp_state(input int k, input int f, input int m, input bit is_mem);
    if (k <= f)                       return 0;
    else if (k == f + 1)              return 1;
    else if (k == f + 2)              return 2;
    else if (is_mem && k <= f + 3 + m) return 3;
    else                              return 4;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs; mem_ready is random noise whenever no access
  // is expected, and branch_taken is only meaningful in the execute cycle.
  task automatic drive_inputs(input logic [6:0] opc, input int k, input int f,
                              input int m, input logic bt, input bit is_mem);
    if (k <= f) begin
      opcode    = 7'($urandom);
      mem_ready = (k == f);
    end else begin
      opcode = opc;
      if (is_mem && k >= f + 3 && k <= f + 3 + m) mem_ready = (k == f + 3 + m);
      else                                       mem_ready = 1'($urandom);
    end
    branch_taken = (k == f + 2) ? bt : 1'($urandom);
  endtask

  // Issues one full instruction; called at posedge+1.
  task automatic run_instr(input logic [6:0] opc, input int f, input int m, input logic bt);
    logic [W-1:0] e;
    int lat;
    bit is_mem;
    e      = model(opc, f, m, bt);
    lat    = int'(e[4:0]);
    is_mem = (opc == T_LOAD) || (opc == T_STORE);
    exp_q.push_back(e);
    for (int k = 0; k < lat; k++) begin
      drive_inputs(opc, k, f, m, bt, is_mem);
      check("state", 32'(state_o), 32'(exp_state(k, f, m, is_mem)));
      @(posedge clk); #1;
      cyc_tot++;
    end
    ret_tot++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int lat_a = 0, reg_a = 0, pcw_a = 0, mdr_a = 0, ir_a = 0, st_a = 0, a1_a = 0, a0_a = 0;

  // Accumulates per-instruction activity; compares at each retirement
  always @(negedge clk) begin
    logic [W-1:0] obs, e;
    if (rst) begin
      lat_a = 0; reg_a = 0; pcw_a = 0; mdr_a = 0; ir_a = 0; st_a = 0; a1_a = 0; a0_a = 0;
    end else begin
      lat_a++;
      if (reg_we)                  reg_a++;
      if (pc_we)                   pcw_a++;
      if (mdr_we)                  mdr_a++;
      if (ir_we)                   ir_a++;
      if (mem_req && mem_we)       st_a++;
      if (mem_req && mem_addr_sel) a1_a++;
      if (mem_req && !mem_addr_sel) a0_a++;
      if (instret) begin
        obs = {3'b000, pc_src, reg_we ? wb_sel : 2'b00, 2'(reg_a), 2'(pcw_a),
               2'(mdr_a), 2'(ir_a), 4'(st_a), 4'(a1_a), 4'(a0_a), 5'(lat_a)};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL retire_unexpected: got %0h expected none (t=%0t)", obs, $time);
        end else begin
          e = exp_q.pop_front();
          check("retire", obs, e);
        end
        lat_a = 0; reg_a = 0; pcw_a = 0; mdr_a = 0; ir_a = 0; st_a = 0; a1_a = 0; a0_a = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CNT_W-1:0] frozen;
    int f;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_instret_cnt", 32'(instret_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("first_mem_req", 32'(mem_req), 32'd1);

    // Directed: ADDI, BEQ taken / not taken, LW with waits, SW, JAL, JALR
    run_instr(T_OP_IMM, 0, 0, 1'b0);
    run_instr(T_BRANCH, 0, 0, 1'b1);
    run_instr(T_BRANCH, 0, 0, 1'b0);
    run_instr(T_LOAD,   2, 3, 1'b0);
    run_instr(T_STORE,  1, 2, 1'b0);
    run_instr(T_JAL,    0, 0, 1'b0);
    run_instr(T_JALR,   0, 0, 1'b1);
    run_instr(T_FENCE,  1, 0, 1'b1);

    // Random instruction stream
    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 10)], $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Counters
`ifdef MC_PERF_CNT_EN
    check("cycle_cnt", 32'(cycle_cnt), 32'(CNT_W'(cyc_tot)));
    check("instret_cnt", 32'(instret_cnt), 32'(CNT_W'(ret_tot)));
`else
    check("cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("instret_cnt", 32'(instret_cnt), 32'd0);
`endif

    // Store aborted by reset while the write is being requested
    for (int k = 0; k < 4; k++) begin
      drive_inputs(T_STORE, k, 0, 10, 1'b0, 1'b1);
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1;
    check("abort_pre_req_we", 32'({mem_req, mem_we}), 32'b11);
    rst = 1'b1;
    #1;
    check("abort_strobes", 32'(strobes()), 32'd0);
    @(posedge clk); #1;
    check("abort_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_refetch_req", 32'(mem_req), 32'd1);
    run_instr(T_OP, 1, 0, 1'b0);
    run_instr(T_STORE, 0, 1, 1'b0);

    // Illegal opcode: trap after decode, silent until reset
    f = $urandom_range(0, 2);
    for (int k = 0; k <= f + 1; k++) begin
      drive_inputs(7'b1111111, k, f, 0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    check("trap_state", 32'(state_o), 32'd5);
    check("trap_illegal", 32'(illegal), 32'd1);
    frozen = cycle_cnt;
    for (int k = 0; k < 20; k++) begin
      opcode       = 7'($urandom);
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      check("trap_strobes", 32'(strobes()), 32'd0);
      @(posedge clk); #1;
    end
    check("trap_hold_state", 32'(state_o), 32'd5);
    check("trap_hold_illegal", 32'(illegal), 32'd1);
`ifdef MC_PERF_CNT_EN
    check("trap_cnt_frozen", 32'(cycle_cnt), 32'(frozen));
`else
    check("trap_cnt_zero", 32'(cycle_cnt), 32'd0);
`endif
    rst = 1'b1;
    #1;
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    run_instr(T_LUI, 0, 0, 1'b0);
    run_instr(T_LOAD, 0, 0, 1'b0);

    // Let the monitor drain, then report
    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
